bcd_arbiter: RTL
================

BCD_ARBITER -- requirements
Module: bcd_arbiter

Interface
REQ-001 Parameter: LATENCY, default 2, is the number of clk cycles from a bcd_number change to stable bcd_digits; legal range 1..15.
REQ-002 Port: clk  input  1  rising-edge system clock; the block SHALL use this single clock.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: req0  input  1  requester 0 conversion request, level.
REQ-005 Port: number0  input  26  requester 0 binary value.
REQ-006 Port: req1  input  1  requester 1 conversion request, level.
REQ-007 Port: number1  input  26  requester 1 binary value.
REQ-008 Port: ack0  output  1  one-cycle pulse: result valid for requester 0.
REQ-009 Port: ack1  output  1  one-cycle pulse: result valid for requester 1.
REQ-010 Port: result  output  32  packed BCD {tenMil,mil,hundredThousand,tenThousand,thousand,hundred,ten,one}, 4 bits each.
REQ-011 Port: busy  output  1  high while a conversion is in flight.
REQ-012 Port: bcd_number  output  26  registered drive to the shared bcd converter's number input.
REQ-013 Port: bcd_digits  input  32  shared bcd converter outputs, packed in the same order as result.

Function
REQ-014 FSM states SHALL be IDLE and WAIT only.
REQ-015 In IDLE with req0 or req1 high at a clk edge E0, the block SHALL grant exactly one requester, load bcd_number with that requester's number, clear the wait counter, set busy, and enter WAIT at E0.
REQ-016 Arbitration: with one request high, that requester is granted; with both high, the requester not granted last SHALL win (round-robin); after reset, requester 0 wins the first tie.
REQ-017 The granted number SHALL be sampled only at E0; later changes to number0/number1 or req deassertion SHALL NOT affect the in-flight conversion.
REQ-018 In WAIT the counter SHALL increment each cycle; at edge E0+LATENCY the block SHALL capture bcd_digits into result, pulse the granted ack for exactly one cycle, clear busy, and return to IDLE.
REQ-019 Latency: ack and result valid in the cycle following edge E0+LATENCY; a new grant is possible no earlier than edge E0+LATENCY+1.
REQ-020 result SHALL hold its last captured value until the next capture; ack0 and ack1 SHALL never be high together.
REQ-021 Requests arriving during WAIT SHALL be ignored until IDLE; a requester still holding req in its ack cycle SHALL be considered again at the next IDLE edge under REQ-016, so a continuously asserting pair alternates grants.
REQ-022 bcd_number SHALL hold its value between grants (no change in IDLE).
REQ-023 No width checks are needed: the 26-bit maximum 67,108,863 fits 8 BCD digits.

Reset
REQ-024 While rst is high at a clk edge: state IDLE, ack0=0, ack1=0, busy=0, result=0, bcd_number=0, counter=0, round-robin pointer = requester 1 last granted.
REQ-025 Reset asserted mid-WAIT SHALL abort the conversion with no ack pulse; reset SHALL take priority over all other events in the same cycle.

Verification (bench instantiates the real bcd converter on bcd_number/bcd_digits, LATENCY=2)
REQ-026 req0=1, number0=1337 after reset -> busy high for 2 cycles, then ack0 one-cycle pulse with result=32'h00001337; ack1 stays 0.
REQ-027 req0 and req1 both rise in the same cycle after reset, both held -> ack0 first (number0), then ack1 (number1), then ack0, strictly alternating; never both acks high.
REQ-028 number1=67108863 on req1 -> result=32'h67108863; number1=0 -> result=32'h00000000.
REQ-029 number0 changed from 1337 to 42 one cycle after grant -> result still 32'h00001337.
REQ-030 rst pulsed during WAIT -> no ack pulse, busy=0, result=0, bcd_number=0; next req1 completes normally.
REQ-031 req1 pulsed during an in-flight req0 conversion and dropped before IDLE -> no grant for requester 1, no ack1.

Source files
------------

// File: rtl/bcd_arbiter.sv
// Round-robin arbiter sharing one external binary-to-BCD converter between two requesters.
// A grant drives the converter's input, waits LATENCY cycles, then captures the digits and acks the granted requester.
module bcd_arbiter #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [25:0] number0,
    input  logic        req1,
    input  logic [25:0] number1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] result,
    output logic        busy,
    output logic [25:0] bcd_number,
    input  logic [31:0] bcd_digits
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // The counter reads LATENCY-1 just before edge E0+LATENCY, which is the capture edge.
    localparam logic [3:0] CNT_LAST = 4'(LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        gnt_q, gnt_d;      // requester in flight: 0 or 1
    logic        last_q, last_d;    // requester granted most recently
    logic        ack0_d, ack1_d;
    logic        busy_d;
    logic [31:0] result_d;
    logic [25:0] number_d;
    logic        pick1;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        busy_d   = busy;
        result_d = result;
        number_d = bcd_number;
        pick1    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // On a tie the requester not granted last wins.
                    pick1    = req1 && (!req0 || !last_q);
                    gnt_d    = pick1;
                    last_d   = pick1;
                    number_d = pick1 ? number1 : number0;
                    cnt_d    = 4'd0;
                    busy_d   = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    result_d = bcd_digits;
                    ack0_d   = !gnt_q;
                    ack1_d   = gnt_q;
                    busy_d   = 1'b0;
                    cnt_d    = 4'd0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            gnt_q      <= 1'b0;
            last_q     <= 1'b1;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            busy       <= 1'b0;
            result     <= 32'd0;
            bcd_number <= 26'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            ack0       <= ack0_d;
            ack1       <= ack1_d;
            busy       <= busy_d;
            result     <= result_d;
            bcd_number <= number_d;
        end
    end

endmodule
